// File: rtl/fht_pkg.sv
// fht_pkg: shared sizes, FSM encoding and line-word type for the FHT result unloader.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fht_pkg;

   localparam int A_BIT     = 8;
   localparam int D_BIT     = 16;
   localparam int BANK_SIZE = 1 << A_BIT;
   localparam int N_POINTS  = 4 * BANK_SIZE;
   localparam int K_BIT     = A_BIT + 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // One bank read returns four consecutive points; lane 0 (bank 0) sits in the low bits.
   typedef logic [4*D_BIT-1:0] line_t;

   function automatic logic [D_BIT-1:0] lane_sel(input line_t line, input logic [1:0] lane);
      logic [D_BIT-1:0] v;
      case (lane)
         2'd0:    v = line[0*D_BIT +: D_BIT];
         2'd1:    v = line[1*D_BIT +: D_BIT];
         2'd2:    v = line[2*D_BIT +: D_BIT];
         default: v = line[3*D_BIT +: D_BIT];
      endcase
      return v;
   endfunction

endpackage

// File: rtl/fht_unload_if.sv
// fht_unload_if: control, bank-read and output-stream signals of the result unloader.
// Latency: none (wiring only).
// Backpressure: carries the oVALID/iREADY stream handshake.
interface fht_unload_if;
   import fht_pkg::*;

   logic             iRDY;
   logic             iSOURCE_DATA;
   logic             iSTART;
   logic [A_BIT-1:0] oADDR_RD;
   logic             oRD_EN;
   logic             oSEL_B;
   logic [D_BIT-1:0] iDATA_0;
   logic [D_BIT-1:0] iDATA_1;
   logic [D_BIT-1:0] iDATA_2;
   logic [D_BIT-1:0] iDATA_3;
   logic [D_BIT-1:0] oDATA;
   logic [K_BIT-1:0] oINDEX;
   logic             oVALID;
   logic             iREADY;
   logic             oLAST;
   logic             oBUSY;
   logic             oDONE;

   modport master (
      input  iRDY, iSOURCE_DATA, iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
      output oADDR_RD, oRD_EN, oSEL_B, oDATA, oINDEX, oVALID, oLAST, oBUSY, oDONE
   );

   modport slave (
      output iRDY, iSOURCE_DATA, iSTART, iDATA_0, iDATA_1, iDATA_2, iDATA_3, iREADY,
      input  oADDR_RD, oRD_EN, oSEL_B, oDATA, oINDEX, oVALID, oLAST, oBUSY, oDONE
   );

endinterface

// File: rtl/fht_line_buf.sv
// fht_line_buf: 2-entry FIFO of four-point lines between the bank read port and the serializer.
// Latency: a pushed line is visible at the head on the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; flush empties it at once.
module fht_line_buf
   import fht_pkg::*;
(
   input  logic       iCLK,
   input  logic       iRESET,
   input  logic       i_push,
   input  line_t      i_push_dat,
   input  logic       i_pop,
   input  logic       i_flush,
   output line_t      o_head_dat,
   output logic       o_full,
   output logic       o_empty,
   output logic [1:0] o_count
);

   line_t      r_mem [2];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign o_full     = (r_count == 2'd2);
   assign o_empty    = (r_count == 2'd0);
   assign o_count    = r_count;
   assign o_head_dat = r_mem[r_rd_ptr];
   assign w_push     = i_push && !o_full;
   assign w_pop      = i_pop && !o_empty;

   // Storage write: only the slot addressed by the write pointer changes.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      end else if (w_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // Pointers and occupancy; flush wins over a same-cycle push or pop.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else if (i_flush) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/fht_unload.sv
// fht_unload: drains the final FHT bank set in natural point order onto a valid/ready stream.
// Latency: first point valid 2 cycles after oBUSY rises, then one point per cycle with iREADY high.
// Backpressure: output holds while stalled; reads stop once buffered plus in-flight lines reach 2.
module fht_unload
   import fht_pkg::*;
(
   input  logic         iCLK,
   input  logic         iRESET,
   fht_unload_if.master io_bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_rdy_q;
   logic             r_sel_b;
   logic             r_inflight;
   logic             r_done;
   logic [A_BIT-1:0] r_rd_addr;
   logic [A_BIT-1:0] r_out_addr;
   logic [1:0]       r_lane;

   logic             w_start;
   logic             w_trigger;
   logic             w_launch;
   logic             w_busy;
   logic             w_rd_en;
   logic             w_valid;
   logic             w_xfer;
   logic             w_pop;
   logic             w_last_k;
   logic             w_last_xfer;
   logic [K_BIT-1:0] w_index;
   line_t            w_line_in;
   line_t            w_head;
   logic             w_full;
   logic             w_empty;
   logic [1:0]       w_count;

   // A start pulse aborts everything, including a trigger in the same cycle.
   assign w_start     = io_bus.iSTART;
   assign w_trigger   = !r_rdy_q && io_bus.iRDY;
   assign w_launch    = (r_state == IDLE) && w_trigger && !w_start;
   assign w_line_in   = {io_bus.iDATA_3, io_bus.iDATA_2, io_bus.iDATA_1, io_bus.iDATA_0};
   assign w_valid     = !w_empty;
   assign w_xfer      = w_valid && io_bus.iREADY;
   assign w_pop       = w_xfer && (r_lane == 2'd3);
   assign w_index     = {r_out_addr, r_lane};
   assign w_last_k    = (w_index == K_BIT'(N_POINTS - 1));
   assign w_last_xfer = w_xfer && w_last_k;

   fht_line_buf u_line_buf (
      .iCLK       (iCLK),
      .iRESET     (iRESET),
      .i_push     (r_inflight),
      .i_push_dat (w_line_in),
      .i_pop      (w_pop),
      .i_flush    (w_start),
      .o_head_dat (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   // FSM state register.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state: RUN issues all reads, DRAIN waits for the final point to leave.
   always_comb begin
      w_state_nxt = r_state;
      if (w_start) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_trigger) w_state_nxt = RUN;
            RUN:     if (w_rd_en && (r_rd_addr == A_BIT'(BANK_SIZE - 1))) w_state_nxt = DRAIN;
            DRAIN:   if (w_last_xfer) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   // FSM outputs: a read goes out only if its line is guaranteed a buffer slot on return.
   always_comb begin
      w_busy  = (r_state != IDLE);
      w_rd_en = (r_state == RUN) && !w_start && !w_full &&
                (({1'b0, w_count} + {2'b0, r_inflight}) < 3'd2);
   end

   // Ready level history; starts high so a level already up after reset never triggers.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) r_rdy_q <= 1'b1;
      else        r_rdy_q <= io_bus.iRDY;
   end

   // Bank-set select captured once per unload.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET)        r_sel_b <= 1'b0;
      else if (w_launch) r_sel_b <= io_bus.iSOURCE_DATA;
   end

   // Read address counter and the single-cycle in-flight read marker.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_rd_addr  <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         if (w_start || w_launch) r_rd_addr <= '0;
         else if (w_rd_en)        r_rd_addr <= r_rd_addr + 1'b1;
      end
   end

   // Serializer: lane walks 0..3 within the head line, line address advances on each pop.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_lane     <= 2'd0;
         r_out_addr <= '0;
      end else if (w_start || w_launch) begin
         r_lane     <= 2'd0;
         r_out_addr <= '0;
      end else if (w_xfer) begin
         r_lane <= r_lane + 2'd1;
         if (w_pop) r_out_addr <= r_out_addr + 1'b1;
      end
   end

   // Completion pulse in the cycle after the last point is accepted.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) r_done <= 1'b0;
      else        r_done <= w_last_xfer && !w_start;
   end

   assign io_bus.oADDR_RD = r_rd_addr;
   assign io_bus.oRD_EN   = w_rd_en;
   assign io_bus.oSEL_B   = r_sel_b;
   assign io_bus.oVALID   = w_valid;
   assign io_bus.oDATA    = w_valid ? lane_sel(w_head, r_lane) : '0;
   assign io_bus.oINDEX   = w_valid ? w_index : '0;
   assign io_bus.oLAST    = w_valid && w_last_k;
   assign io_bus.oBUSY    = w_busy;
   assign io_bus.oDONE    = r_done;

endmodule

// File: tb/tb_fht_unload.sv
// tb_fht_unload: bench for the FHT result unloader with a bank-memory model and point scoreboard.
// Latency: bank model returns data one cycle after each read strobe.
// Backpressure: consumer ready is driven full, random, held low, per scenario.
module tb_fht_unload;
   import fht_pkg::*;

   logic iCLK   = 1'b0;
   logic iRESET = 1'b1;

   fht_unload_if bus();

   fht_unload dut (
      .iCLK   (iCLK),
      .iRESET (iRESET),
      .io_bus (bus)
   );

   always #5 iCLK = ~iCLK;

   int n_cmp  = 0;
   int n_bad  = 0;
   int rd_cnt = 0;

   logic [D_BIT-1:0] exp_d[$];
   logic [K_BIT-1:0] exp_k[$];

   // Bank RAM model: bank b at address a holds b*1000 + a, one-cycle read latency.
   always @(posedge iCLK) begin
      if (bus.oRD_EN === 1'b1) begin
         rd_cnt      <= rd_cnt + 1;
         bus.iDATA_0 <= D_BIT'(bus.oADDR_RD);
         bus.iDATA_1 <= D_BIT'(1000) + D_BIT'(bus.oADDR_RD);
         bus.iDATA_2 <= D_BIT'(2000) + D_BIT'(bus.oADDR_RD);
         bus.iDATA_3 <= D_BIT'(3000) + D_BIT'(bus.oADDR_RD);
      end
   end

   // Loads the scoreboard with the full expected stream, then produces a ready rising edge.
   task automatic do_trigger(input logic src);
      exp_d.delete();
      exp_k.delete();
      for (int k = 0; k < N_POINTS; k++) begin
         exp_d.push_back(D_BIT'((k % 4) * 1000 + k / 4));
         exp_k.push_back(K_BIT'(k));
      end
      @(negedge iCLK); bus.iRDY = 1'b0;
      @(negedge iCLK); bus.iRDY = 1'b1; bus.iSOURCE_DATA = src;
      @(negedge iCLK);
   endtask

   task automatic test_reset();
      int viol = 0;
      bus.iRDY = 1'b1; bus.iSOURCE_DATA = 1'b0; bus.iSTART = 1'b0; bus.iREADY = 1'b1;
      repeat (3) @(negedge iCLK);
      n_cmp++;
      if (bus.oBUSY !== 1'b0 || bus.oVALID !== 1'b0 || bus.oDONE !== 1'b0 || bus.oLAST !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_status: busy=%b valid=%b done=%b last=%b, required all 0",
                  bus.oBUSY, bus.oVALID, bus.oDONE, bus.oLAST);
      end
      n_cmp++;
      if (bus.oRD_EN !== 1'b0 || bus.oADDR_RD !== '0 || bus.oSEL_B !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_read: rd_en=%b addr=%0d sel_b=%b, required all 0",
                  bus.oRD_EN, bus.oADDR_RD, bus.oSEL_B);
      end
      n_cmp++;
      if (bus.oDATA !== '0 || bus.oINDEX !== '0) begin
         n_bad++;
         $display("FAIL reset_data: data=%0d index=%0d, required 0/0", bus.oDATA, bus.oINDEX);
      end
      iRESET = 1'b0;
      repeat (100) begin
         @(negedge iCLK);
         if (bus.oBUSY !== 1'b0 || bus.oVALID !== 1'b0 || bus.oRD_EN !== 1'b0) viol++;
      end
      n_cmp++;
      if (viol != 0) begin
         n_bad++;
         $display("FAIL reset_no_trigger: %0d active cycles, required 0", viol);
      end
   endtask

   task automatic test_full_stream();
      int got = 0, cyc = 0, lat = 0, bubbles = 0;
      logic [D_BIT-1:0] e_d;
      logic [K_BIT-1:0] e_k;
      bus.iREADY = 1'b1;
      do_trigger(1'b1);
      n_cmp++;
      if (bus.oBUSY !== 1'b1 || bus.oSEL_B !== 1'b1) begin
         n_bad++;
         $display("FAIL trigger_state: busy=%b sel_b=%b, required 1/1", bus.oBUSY, bus.oSEL_B);
      end
      while (bus.oVALID !== 1'b1 && lat < 10) begin @(negedge iCLK); lat++; end
      n_cmp++;
      if (lat != 2) begin
         n_bad++;
         $display("FAIL first_latency: %0d cycles after busy, required 2", lat);
      end
      while (got < N_POINTS && cyc < 4 * N_POINTS) begin
         if (bus.oVALID !== 1'b1) bubbles++;
         if (bus.oVALID === 1'b1 && bus.iREADY === 1'b1) begin
            n_cmp++;
            if (exp_d.size() == 0) begin
               n_bad++; $display("FAIL full_extra: index %0d, required no more points", bus.oINDEX);
            end else begin
               e_d = exp_d.pop_front(); e_k = exp_k.pop_front();
               if (bus.oDATA !== e_d || bus.oINDEX !== e_k || bus.oLAST !== (e_k == K_BIT'(N_POINTS - 1))) begin
                  n_bad++;
                  $display("FAIL full_point: data=%0d idx=%0d last=%b, required data=%0d idx=%0d",
                           bus.oDATA, bus.oINDEX, bus.oLAST, e_d, e_k);
               end
            end
            got++;
         end
         @(negedge iCLK); cyc++;
      end
      n_cmp++;
      if (got != N_POINTS || bubbles != 0) begin
         n_bad++;
         $display("FAIL full_count: %0d points with %0d bubbles, required %0d with 0", got, bubbles, N_POINTS);
      end
      n_cmp++;
      if (bus.oDONE !== 1'b1 || bus.oBUSY !== 1'b0) begin
         n_bad++;
         $display("FAIL full_done: done=%b busy=%b, required 1/0", bus.oDONE, bus.oBUSY);
      end
      @(negedge iCLK);
      n_cmp++;
      if (bus.oDONE !== 1'b0) begin
         n_bad++;
         $display("FAIL done_pulse: done=%b one cycle later, required 0", bus.oDONE);
      end
   endtask

   task automatic test_random_ready();
      int got = 0, cyc = 0, rd_base;
      logic prev_stall = 1'b0;
      logic [D_BIT-1:0] prev_d = '0, e_d;
      logic [K_BIT-1:0] prev_k = '0, e_k;
      rd_base = rd_cnt;
      bus.iREADY = 1'b0;
      do_trigger(1'b0);
      while (got < N_POINTS && cyc < 20 * N_POINTS) begin
         bus.iREADY = 1'($urandom_range(0, 1));
         if (prev_stall) begin
            n_cmp++;
            if (bus.oVALID !== 1'b1 || bus.oDATA !== prev_d || bus.oINDEX !== prev_k) begin
               n_bad++;
               $display("FAIL stall_hold: valid=%b data=%0d idx=%0d, required 1/%0d/%0d",
                        bus.oVALID, bus.oDATA, bus.oINDEX, prev_d, prev_k);
            end
         end
         prev_stall = (bus.oVALID === 1'b1) && !bus.iREADY;
         prev_d = bus.oDATA;
         prev_k = bus.oINDEX;
         if (bus.oVALID === 1'b1 && bus.iREADY === 1'b1) begin
            n_cmp++;
            if (exp_d.size() == 0) begin
               n_bad++; $display("FAIL random_extra: index %0d, required no more points", bus.oINDEX);
            end else begin
               e_d = exp_d.pop_front(); e_k = exp_k.pop_front();
               if (bus.oDATA !== e_d || bus.oINDEX !== e_k || bus.oLAST !== (e_k == K_BIT'(N_POINTS - 1))) begin
                  n_bad++;
                  $display("FAIL random_point: data=%0d idx=%0d last=%b, required data=%0d idx=%0d",
                           bus.oDATA, bus.oINDEX, bus.oLAST, e_d, e_k);
               end
            end
            got++;
         end
         @(negedge iCLK); cyc++;
      end
      n_cmp++;
      if (got != N_POINTS || bus.oDONE !== 1'b1) begin
         n_bad++;
         $display("FAIL random_done: %0d points done=%b, required %0d and 1", got, bus.oDONE, N_POINTS);
      end
      n_cmp++;
      if (rd_cnt - rd_base != BANK_SIZE) begin
         n_bad++;
         $display("FAIL random_reads: %0d reads, required %0d", rd_cnt - rd_base, BANK_SIZE);
      end
   endtask

   task automatic test_backpressure();
      int got = 0, cyc = 0, lat = 0, viol = 0, rd_base;
      logic [D_BIT-1:0] e_d;
      logic [K_BIT-1:0] e_k;
      rd_base = rd_cnt;
      bus.iREADY = 1'b0;
      do_trigger(1'b0);
      while (bus.oVALID !== 1'b1 && lat < 10) begin @(negedge iCLK); lat++; end
      repeat (50) begin
         if (bus.oVALID !== 1'b1 || bus.oINDEX !== exp_k[0] || bus.oDATA !== exp_d[0]) viol++;
         @(negedge iCLK);
      end
      n_cmp++;
      if (viol != 0) begin
         n_bad++;
         $display("FAIL bp_hold: %0d cycles not holding k=0 (now idx=%0d), required 0", viol, bus.oINDEX);
      end
      n_cmp++;
      if (rd_cnt - rd_base > 3 || bus.oSEL_B !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_reads: %0d reads sel_b=%b, required at most 3 and 0", rd_cnt - rd_base, bus.oSEL_B);
      end
      bus.iREADY = 1'b1;
      while (got < N_POINTS && cyc < 4 * N_POINTS) begin
         if (bus.oVALID === 1'b1) begin
            n_cmp++;
            if (exp_d.size() == 0) begin
               n_bad++; $display("FAIL bp_extra: index %0d, required no more points", bus.oINDEX);
            end else begin
               e_d = exp_d.pop_front(); e_k = exp_k.pop_front();
               if (bus.oDATA !== e_d || bus.oINDEX !== e_k) begin
                  n_bad++;
                  $display("FAIL bp_point: data=%0d idx=%0d, required data=%0d idx=%0d",
                           bus.oDATA, bus.oINDEX, e_d, e_k);
               end
            end
            got++;
         end
         @(negedge iCLK); cyc++;
      end
      n_cmp++;
      if (got != N_POINTS || bus.oDONE !== 1'b1 || bus.oBUSY !== 1'b0) begin
         n_bad++;
         $display("FAIL bp_done: %0d points done=%b busy=%b, required %0d/1/0", got, bus.oDONE, bus.oBUSY, N_POINTS);
      end
   endtask

   task automatic test_abort();
      int cyc = 0, viol = 0;
      logic [D_BIT-1:0] e_d;
      logic [K_BIT-1:0] e_k;
      bus.iREADY = 1'b1;
      do_trigger(1'b1);
      while (cyc < 4 * N_POINTS) begin
         if (bus.oVALID === 1'b1 && bus.oINDEX === K_BIT'(500)) break;
         if (bus.oVALID === 1'b1) begin
            n_cmp++;
            if (exp_d.size() == 0) begin
               n_bad++; $display("FAIL abort_extra: index %0d, required no more points", bus.oINDEX);
            end else begin
               e_d = exp_d.pop_front(); e_k = exp_k.pop_front();
               if (bus.oDATA !== e_d || bus.oINDEX !== e_k) begin
                  n_bad++;
                  $display("FAIL abort_point: data=%0d idx=%0d, required data=%0d idx=%0d",
                           bus.oDATA, bus.oINDEX, e_d, e_k);
               end
            end
         end
         @(negedge iCLK); cyc++;
      end
      n_cmp++;
      if (bus.oINDEX !== K_BIT'(500)) begin
         n_bad++;
         $display("FAIL abort_reach: idx=%0d, required 500", bus.oINDEX);
      end
      bus.iSTART = 1'b1;
      @(negedge iCLK);
      bus.iSTART = 1'b0;
      n_cmp++;
      if (bus.oVALID !== 1'b0 || bus.oBUSY !== 1'b0 || bus.oDONE !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_stop: valid=%b busy=%b done=%b, required 0/0/0", bus.oVALID, bus.oBUSY, bus.oDONE);
      end
      repeat (30) begin
         if (bus.oVALID !== 1'b0 || bus.oBUSY !== 1'b0 || bus.oDONE !== 1'b0) viol++;
         @(negedge iCLK);
      end
      n_cmp++;
      if (viol != 0) begin
         n_bad++;
         $display("FAIL abort_quiet: %0d active cycles after abort, required 0", viol);
      end
   endtask

   task automatic test_start_vs_trigger();
      int viol = 0;
      @(negedge iCLK); bus.iRDY = 1'b0;
      @(negedge iCLK); bus.iRDY = 1'b1; bus.iSTART = 1'b1;
      @(negedge iCLK); bus.iRDY = 1'b0; bus.iSTART = 1'b0;
      repeat (20) begin
         if (bus.oBUSY !== 1'b0 || bus.oRD_EN !== 1'b0 || bus.oVALID !== 1'b0) viol++;
         @(negedge iCLK);
      end
      n_cmp++;
      if (viol != 0) begin
         n_bad++;
         $display("FAIL start_beats_trigger: %0d active cycles, required 0", viol);
      end
   endtask

   task automatic test_restart_retrigger();
      int got = 0, cyc = 0, viol = 0;
      logic [D_BIT-1:0] e_d;
      logic [K_BIT-1:0] e_k;
      bus.iREADY = 1'b1;
      do_trigger(1'b0);
      while (got < N_POINTS && cyc < 4 * N_POINTS) begin
         if (got == 100) bus.iRDY = 1'b0;
         if (got == 110) bus.iRDY = 1'b1;
         if (bus.oVALID === 1'b1) begin
            n_cmp++;
            if (exp_d.size() == 0) begin
               n_bad++; $display("FAIL restart_extra: index %0d, required no more points", bus.oINDEX);
            end else begin
               e_d = exp_d.pop_front(); e_k = exp_k.pop_front();
               if (bus.oDATA !== e_d || bus.oINDEX !== e_k || bus.oLAST !== (e_k == K_BIT'(N_POINTS - 1))) begin
                  n_bad++;
                  $display("FAIL restart_point: data=%0d idx=%0d last=%b, required data=%0d idx=%0d",
                           bus.oDATA, bus.oINDEX, bus.oLAST, e_d, e_k);
               end
            end
            got++;
         end
         @(negedge iCLK); cyc++;
      end
      n_cmp++;
      if (got != N_POINTS || bus.oDONE !== 1'b1 || bus.oBUSY !== 1'b0) begin
         n_bad++;
         $display("FAIL restart_done: %0d points done=%b busy=%b, required %0d/1/0", got, bus.oDONE, bus.oBUSY, N_POINTS);
      end
      @(negedge iCLK);
      repeat (20) begin
         if (bus.oBUSY !== 1'b0 || bus.oVALID !== 1'b0 || bus.oDONE !== 1'b0) viol++;
         @(negedge iCLK);
      end
      n_cmp++;
      if (viol != 0) begin
         n_bad++;
         $display("FAIL retrigger_ignored: %0d active cycles after done, required 0", viol);
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_full_stream();
      test_random_ready();
      test_backpressure();
      test_abort();
      test_start_vs_trigger();
      test_restart_retrigger();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fht_unload.md
# fht_unload

Result unloader for the FHT core: once the FHT control asserts ready at the end of the last stage, this block reads the four result banks of the final bank set in natural point order and streams the N = 4·2^A_BIT points out over a valid/ready interface. It sits between the bank RAM read ports and the downstream consumer. It holds a busy flag so the system does not restart the transform while results are still being drained.

## Interface
- A_BIT, 8, bank address width; BANK_SIZE = 2^A_BIT, N = 4·BANK_SIZE points
- D_BIT, 16, sample width
- iCLK  in  1  clock, all logic on rising edge
- iRESET  in  1  asynchronous, active-high reset
- iRDY  in  1  FHT control ready level; a 0→1 transition triggers an unload
- iSOURCE_DATA  in  1  final bank set holding results: 0 = set A, 1 = set B; sampled at trigger
- iSTART  in  1  FHT start pulse; aborts an unload in progress
- oADDR_RD  out  A_BIT  read address, common to banks 0..3
- oRD_EN  out  1  read strobe to the selected bank set
- oSEL_B  out  1  registered copy of iSOURCE_DATA at trigger
- iDATA_0..iDATA_3  in  D_BIT each  bank read data, valid 1 cycle after oRD_EN
- oDATA  out  D_BIT  output point
- oINDEX  out  A_BIT+2  point index k of oDATA
- oVALID  out  1  oDATA/oINDEX valid
- iREADY  in  1  consumer accepts
- oLAST  out  1  high with oVALID when k = N-1
- oBUSY  out  1  unload in progress
- oDONE  out  1  one-cycle pulse after the last transfer

## Operation
- Point mapping: point k is in bank k[1:0] at address k[A_BIT+1:2]. One read at address a returns points 4a..4a+3.
- Trigger: iRDY is registered into rdy_q, which resets to 1. A trigger is rdy_q = 0 and iRDY = 1. A level already high after reset never triggers.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN on trigger. Set oBUSY, latch oSEL_B, zero the address counter.
  - RUN: issue oRD_EN with oADDR_RD = a whenever the line buffer has a free slot, counting in-flight reads. a increments per read. After the read with a = BANK_SIZE-1 is issued → DRAIN.
  - DRAIN: no reads. After the transfer with k = N-1 → IDLE, with oDONE pulsed and oBUSY cleared.
- Line buffer: 2 entries × 4·D_BIT, filled from iDATA_0..3 one cycle after each oRD_EN. A read is issued only if the occupied entries plus in-flight reads are below 2, so it never overflows.
- Serializer: a 2-bit lane counter selects bank lane 0..3 of the head entry. The entry is popped on the transfer of lane 3.
- Handshake: a transfer occurs on oVALID & iREADY. While oVALID & !iREADY, oDATA, oINDEX and oLAST hold stable. oVALID never drops without a transfer, except on abort.
- Abort: iSTART while oBUSY → IDLE on the next edge. The buffer is flushed, oVALID/oBUSY go to 0, in-flight data is discarded, and no oDONE is issued.
- Simultaneous trigger and iSTART: iSTART wins and the FSM stays IDLE.
- A trigger while already busy is ignored.
- Index widths: oINDEX is the {address, lane} concatenation. It wraps only via the FSM, with no arithmetic overflow.

## Timing
- Reset values:
  - oADDR_RD = 0, oRD_EN = 0, oSEL_B = 0, oDATA = 0, oINDEX = 0
  - oVALID = 0, oLAST = 0, oBUSY = 0, oDONE = 0
  - state = IDLE, rdy_q = 1
- Edge E0 samples the trigger: oBUSY = 1 after E0.
- First oRD_EN (a = 0) is high in the cycle after E0 and is sampled by the RAM at E1.
- iDATA is valid in the cycle after E1 and captured at E2.
- First oVALID (k = 0) is high after E2, i.e. 2 cycles after oBUSY rises.
- With iREADY held high: 1 point per cycle, N consecutive transfers, no bubbles.
- oDONE is high in the cycle after the k = N-1 transfer edge; oBUSY falls at the same edge.
- Backpressure: reads stall within 1 cycle of the buffer becoming full and resume once an entry pops.

## Structure
- Shared package fht_pkg holds:
  - BANK_SIZE and N_POINTS derived from A_BIT
  - the FSM state encoding (IDLE, RUN, DRAIN)
  - the line-word type (4·D_BIT)
- Sub-module fht_line_buf: 2-entry FIFO of 4·D_BIT with push, pop, full/empty and occupancy count. The FSM, read issue and serializer stay in fht_unload.

## Test plan
- Reset with iRDY = 1 and no edge → oBUSY, oVALID and oRD_EN stay 0 for 100 cycles.
- Bank model: value = bank·1000 + addr. Trigger with iSOURCE_DATA = 1 and iREADY = 1 → oSEL_B = 1, first oVALID 2 cycles after oBUSY rises. Stream is k = 0..1023 with oDATA = (k%4)·1000 + k/4. oLAST only at k = 1023, oDONE 1 cycle later.
- Random iREADY (50%) → same 1024-value sequence, no duplicates or drops. oDATA stays stable while stalled. oRD_EN count = 256.
- iREADY held 0 for 50 cycles after first oVALID → at most 2 reads issued beyond the first, and oDATA stays at k = 0.
- iSTART at k = 500 → oVALID = 0 and oBUSY = 0 on the next cycle, no oDONE. A new iRDY edge restarts from k = 0.
- iRDY pulse and iSTART in the same cycle → no unload. A trigger during an active unload → ignored, and the sequence completes normally.
